// File: rtl/maj_vote_monitor.sv
// Majority-voter health monitor: per-channel OK/SUSPECT/FAILED tracking, voter cross-check and disagreement count.
// Latency 1 cycle, outputs registered, no backpressure (en gates sampling); `define MAJ_MON_RECOVER_EN adds FAILED->OK recovery.
module maj_vote_monitor #(
  parameter int unsigned FAIL_THRESH = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TOT_W       = 16,
  parameter int unsigned RECOVER_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x2,
  input  logic             x1,
  input  logic             x0,
  input  logic             y,
  input  logic             clr_fail,
  output logic [2:0]       suspect,
  output logic [2:0]       fail,
  output logic             all_agree,
  output logic             voter_err,
  output logic [TOT_W-1:0] tot_mism
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAIL_THRESH);

  state_e           st_q  [3];
  state_e           st_d  [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
`ifdef MAJ_MON_RECOVER_EN
  localparam logic [CNT_W-1:0] RCV_TGT = CNT_W'(RECOVER_CNT);
  logic [CNT_W-1:0] rcv_q [3];
  logic [CNT_W-1:0] rcv_d [3];
`endif
  logic             all_agree_q, all_agree_d;
  logic             voter_err_q, voter_err_d;
  logic [TOT_W-1:0] tot_q, tot_d;

  logic [2:0] x_vec;
  logic       agree_now;
  logic       maj_now;

  assign x_vec     = {x2, x1, x0};
  assign agree_now = (x2 == x1) && (x1 == x0);
  assign maj_now   = (x2 & x1) | (x2 & x0) | (x1 & x0);

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
`ifdef MAJ_MON_RECOVER_EN
    rcv_d       = rcv_q;
`endif
    all_agree_d = all_agree_q;
    voter_err_d = voter_err_q;
    tot_d       = tot_q;
    if (clr_fail) begin
      for (int k = 0; k < 3; k++) begin
        st_d[k]  = ST_OK;
        cnt_d[k] = '0;
`ifdef MAJ_MON_RECOVER_EN
        rcv_d[k] = '0;
`endif
      end
      all_agree_d = 1'b1;
      voter_err_d = 1'b0;
      tot_d       = '0;
    end else if (en) begin
      for (int k = 0; k < 3; k++) begin
        case (st_q[k])
          ST_OK: begin
            cnt_d[k] = x_vec[k] != y ? CNT_ONE : '0;
            if (x_vec[k] != y) st_d[k] = (FAIL_THRESH == 1) ? ST_FAILED : ST_SUSPECT;
          end
          ST_SUSPECT: begin
            if (x_vec[k] != y) begin
              cnt_d[k] = cnt_q[k] + CNT_ONE;
              if (cnt_q[k] + CNT_ONE == THRESH) st_d[k] = ST_FAILED;
            end else begin
              st_d[k]  = ST_OK;
              cnt_d[k] = '0;
            end
          end
          ST_FAILED: begin
`ifdef MAJ_MON_RECOVER_EN
            // Only an unbroken run of matches brings a failed channel back.
            if (x_vec[k] != y) begin
              rcv_d[k] = '0;
            end else if (rcv_q[k] + CNT_ONE == RCV_TGT) begin
              st_d[k]  = ST_OK;
              cnt_d[k] = '0;
              rcv_d[k] = '0;
            end else begin
              rcv_d[k] = rcv_q[k] + CNT_ONE;
            end
`endif
          end
          default: begin
            st_d[k]  = ST_OK;
            cnt_d[k] = '0;
          end
        endcase
      end
      all_agree_d = agree_now;
      if (y != maj_now) voter_err_d = 1'b1;
      if (!agree_now && tot_q != '1) tot_d = tot_q + TOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]  <= ST_OK;
        cnt_q[k] <= '0;
`ifdef MAJ_MON_RECOVER_EN
        rcv_q[k] <= '0;
`endif
      end
      all_agree_q <= 1'b1;
      voter_err_q <= 1'b0;
      tot_q       <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
`ifdef MAJ_MON_RECOVER_EN
      rcv_q       <= rcv_d;
`endif
      all_agree_q <= all_agree_d;
      voter_err_q <= voter_err_d;
      tot_q       <= tot_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      suspect[k] = (st_q[k] == ST_SUSPECT);
      fail[k]    = (st_q[k] == ST_FAILED);
    end
  end

  assign all_agree = all_agree_q;
  assign voter_err = voter_err_q;
  assign tot_mism  = tot_q;

endmodule

// File: tb/tb_maj_vote_monitor.sv
// Directed bench for maj_vote_monitor; expected outputs queued per step and checked one edge later.
module tb_maj_vote_monitor;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, en, x2, x1, x0, y, clr_fail;
  logic [2:0]    suspect, fail;
  logic          all_agree, voter_err;
  logic [TW-1:0] tot_mism;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [2:0]    s;
    logic [2:0]    f;
    logic          a;
    logic          v;
    logic [TW-1:0] t;
  } exp_t;

  exp_t exp_q[$];

  maj_vote_monitor #(
    .FAIL_THRESH(4),
    .CNT_W(8),
    .TOT_W(TW),
    .RECOVER_CNT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .x2(x2),
    .x1(x1),
    .x0(x0),
    .y(y),
    .clr_fail(clr_fail),
    .suspect(suspect),
    .fail(fail),
    .all_agree(all_agree),
    .voter_err(voter_err),
    .tot_mism(tot_mism)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
  task automatic step(input string tag, input logic r, input logic e, input logic c,
                      input logic [2:0] x, input logic yy,
                      input logic [2:0] es, input logic [2:0] ef, input logic ea,
                      input logic ev, input int et);
    exp_t ex;
    exp_t got;
    @(negedge clk);
    rst = r; en = e; clr_fail = c; {x2, x1, x0} = x; y = yy;
    ex.tag = tag; ex.s = es; ex.f = ef; ex.a = ea; ex.v = ev; ex.t = TW'(et);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = exp_q.pop_front();
      chk({got.tag, ".suspect"},   16'(suspect),   16'(got.s));
      chk({got.tag, ".fail"},      16'(fail),      16'(got.f));
      chk({got.tag, ".all_agree"}, 16'(all_agree), 16'(got.a));
      chk({got.tag, ".voter_err"}, 16'(voter_err), 16'(got.v));
      chk({got.tag, ".tot_mism"},  16'(tot_mism),  16'(got.t));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_fail = 1'b0; x2 = 1'b0; x1 = 1'b0; x0 = 1'b0; y = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
           3'b000, 3'b000, 1'b1, 1'b0, 0);

    // single fault on x2
    for (int i = 1; i <= 4; i++)
      step("single", 1'b0, 1'b1, 1'b0, 3'b100, 1'b0,
           (i < 4) ? 3'b100 : 3'b000, (i < 4) ? 3'b000 : 3'b100, 1'b0, 1'b0, i);

    // clr_fail wins over an inconsistent sample
    step("clr1", 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 0);

    // transient on x0: 3 mismatches then 1 match, twice
    for (int r = 0; r < 2; r++) begin
      for (int j = 1; j <= 3; j++)
        step("transient_mm", 1'b0, 1'b1, 1'b0, 3'b001, 1'b0,
             3'b001, 3'b000, 1'b0, 1'b0, r * 3 + j);
      step("transient_ok", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0,
           3'b000, 3'b000, 1'b1, 1'b0, r * 3 + 3);
    end

    step("clr2", 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 0);

    // faulty voter: maj(110)=1 but y=0
    step("voter_bad",  1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 3'b110, 3'b000, 1'b0, 1'b1, 1);
    step("voter_hold", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1);
    step("voter_clr",  1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 0);

    // en gating: establish state, then mismatching inputs with en=0
    step("en_setup", 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++)
      step("en_hold", 1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 1);

    // saturation of tot_mism at 2**TW-1; x0 fails on its 4th consecutive mismatch
    for (int i = 1; i <= 20; i++)
      step("saturate", 1'b0, 1'b1, 1'b0, 3'b001, 1'b0,
           (i < 3) ? 3'b001 : 3'b000, (i < 3) ? 3'b000 : 3'b001, 1'b0, 1'b0,
           (1 + i > 15) ? 15 : 1 + i);

    step("clr3", 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 0);

    // recovery: fail channel 1, 7 matches, 1 mismatch, 8 matches
    for (int i = 1; i <= 4; i++)
      step("rcv_fail", 1'b0, 1'b1, 1'b0, 3'b010, 1'b0,
           (i < 4) ? 3'b010 : 3'b000, (i < 4) ? 3'b000 : 3'b010, 1'b0, 1'b0, i);
    for (int i = 0; i < 7; i++)
      step("rcv_match7", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 4);
    step("rcv_break", 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 5);
    for (int i = 1; i <= 8; i++) begin
`ifdef MAJ_MON_RECOVER_EN
      step("rcv_match8", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0,
           3'b000, (i < 8) ? 3'b010 : 3'b000, 1'b1, 1'b0, 5);
`else
      step("rcv_match8", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 5);
`endif
    end

    // reset overrides everything
    step("reset_end", 1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
